ahb_bus_arbiter: RTL and testbench

//  Arbiter for the shared AHB bus between the instruction- and data-memory master wrappers.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/rr_picker.sv | 31 +++
 rtl/ahb_bus_arbiter.sv | 109 ++++++++++
 tb/tb_ahb_bus_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: field widths, HTRANS and HRESP encodings.
package ahb_pkg;

    localparam int unsigned AHB_TRANS_BITS = 2;
    localparam int unsigned AHB_SIZE_BITS  = 3;

    localparam logic [AHB_TRANS_BITS-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [AHB_TRANS_BITS-1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [AHB_TRANS_BITS-1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from start_i, wrapping.
module rr_picker #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    output logic                 valid_c_o,
    output logic [$clog2(N)-1:0] winner_c_o
);

    localparam int unsigned IW = $clog2(N);

    function automatic logic [IW-1:0] wrap_idx(input int unsigned s, input int unsigned off);
        int unsigned v;
        v = s + off;
        if (v >= N) v = v - N;
        return IW'(v);
    endfunction

    always_comb begin
        valid_c_o  = 1'b0;
        winner_c_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_c_o && req_i[wrap_idx(32'(start_i), i)]) begin
                valid_c_o  = 1'b1;
                winner_c_o = wrap_idx(32'(start_i), i);
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with lock support and a beat budget that forces hand-over.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_BURST      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         HReq,
    input  logic [NUM_MASTERS-1:0]         HLock,
    input  logic [AHB_TRANS_BITS-1:0]      HTrans,
    input  logic                           HReady,
    output logic [NUM_MASTERS-1:0]         HGrant,
    output logic [$clog2(NUM_MASTERS)-1:0] HMaster,
    output logic [$clog2(NUM_MASTERS)-1:0] HMasterData,
    output logic                           HMastLock
);

    localparam int unsigned IW = $clog2(NUM_MASTERS);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          gidx_q, gidx_d;
    logic [IW-1:0]          master_q, master_d;
    logic [IW-1:0]          master_data_q, master_data_d;
    logic                   mast_lock_q, mast_lock_d;
    logic [CW-1:0]          beat_q, beat_d;

    logic [IW-1:0] pick_start_c;
    logic          pick_valid_c;
    logic [IW-1:0] pick_winner_c;
    logic [IW-1:0] next_idx_c;
    logic          others_req_c;
    logic          counted_beat_c;

    assign pick_start_c = (gidx_q == IW'(NUM_MASTERS - 1)) ? '0 : gidx_q + IW'(1);

    rr_picker #(
        .N (NUM_MASTERS)
    ) u_rr_picker (
        .req_i      (HReq),
        .start_i    (pick_start_c),
        .valid_c_o  (pick_valid_c),
        .winner_c_o (pick_winner_c)
    );

    assign others_req_c   = |(HReq & ~(NUM_MASTERS'(1) << gidx_q));
    assign counted_beat_c = (HTrans == HTRANS_NONSEQ) || (HTrans == HTRANS_SEQ);

    // Grant priority: locked owner, owner within budget (or uncontended), round-robin, park.
    always_comb begin
        next_idx_c = IW'(DEFAULT_MASTER);
        if (HLock[gidx_q] && HReq[gidx_q]) begin
            next_idx_c = gidx_q;
        end else if (HReq[gidx_q] && ((beat_q < CW'(MAX_BURST)) || !others_req_c)) begin
            next_idx_c = gidx_q;
        end else if (pick_valid_c) begin
            next_idx_c = pick_winner_c;
        end
    end

    // Next state: everything advances only on HReady.
    always_comb begin
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        master_d      = master_q;
        master_data_d = master_data_q;
        mast_lock_d   = mast_lock_q;
        beat_d        = beat_q;
        if (HReady) begin
            master_data_d = master_q;
            master_d      = gidx_q;
            mast_lock_d   = HLock[gidx_q];
            gidx_d        = next_idx_c;
            grant_d       = NUM_MASTERS'(1) << next_idx_c;
            if (next_idx_c != gidx_q) begin
                beat_d = '0;
            end else if (counted_beat_c && (beat_q < CW'(MAX_BURST))) begin
                beat_d = beat_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q       <= NUM_MASTERS'(1) << IW'(DEFAULT_MASTER);
            gidx_q        <= IW'(DEFAULT_MASTER);
            master_q      <= IW'(DEFAULT_MASTER);
            master_data_q <= IW'(DEFAULT_MASTER);
            mast_lock_q   <= 1'b0;
            beat_q        <= '0;
        end else begin
            grant_q       <= grant_d;
            gidx_q        <= gidx_d;
            master_q      <= master_d;
            master_data_q <= master_data_d;
            mast_lock_q   <= mast_lock_d;
            beat_q        <= beat_d;
        end
    end

    assign HGrant      = grant_q;
    assign HMaster     = master_q;
    assign HMasterData = master_data_q;
    assign HMastLock   = mast_lock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios then random traffic against a rule-level model.
module tb_ahb_bus_arbiter;

    localparam int N      = 2;
    localparam int DEF    = 0;
    localparam int MAXB   = 4;

    logic       clk;
    logic       rst;
    logic [1:0] HReq;
    logic [1:0] HLock;
    logic [1:0] HTrans;
    logic       HReady;
    logic [1:0] HGrant;
    logic       HMaster;
    logic       HMasterData;
    logic       HMastLock;

    ahb_bus_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF),
        .MAX_BURST      (MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .HReq        (HReq),
        .HLock       (HLock),
        .HTrans      (HTrans),
        .HReady      (HReady),
        .HGrant      (HGrant),
        .HMaster     (HMaster),
        .HMasterData (HMasterData),
        .HMastLock   (HMastLock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int grant;
        int master;
        int mdata;
        int lock;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state: owner index per pipeline stage and beats spent by the grant holder.
    int mg = DEF, mm = DEF, mmd = DEF, mlk = 0, mcnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick_next(input logic [1:0] req, input logic [1:0] lock);
        int others;
        others = 0;
        for (int k = 0; k < N; k++) if (k != mg && req[k]) others++;
        if (req[mg] && lock[mg]) return mg;
        if (req[mg] && (mcnt < MAXB || others == 0)) return mg;
        for (int k = 1; k <= N; k++) if (req[(mg + k) % N]) return (mg + k) % N;
        return DEF;
    endfunction

    task automatic model_edge(input logic r, input logic [1:0] req, input logic [1:0] lock,
                              input logic [1:0] trans, input logic rdy);
        int ng;
        exp_t e;
        if (r) begin
            mg = DEF; mm = DEF; mmd = DEF; mlk = 0; mcnt = 0;
        end else if (rdy) begin
            ng   = pick_next(req, lock);
            mmd  = mm;
            mm   = mg;
            mlk  = int'(lock[mg]);
            if (ng != mg) mcnt = 0;
            else if (trans[1]) mcnt = (mcnt + 1 > MAXB) ? MAXB : mcnt + 1;
            mg   = ng;
        end
        e.grant  = 1 << mg;
        e.master = mm;
        e.mdata  = mmd;
        e.lock   = mlk;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the falling edge and queue the post-edge expectation.
    task automatic cycle(input logic r, input logic [1:0] req, input logic [1:0] lock,
                         input logic [1:0] trans, input logic rdy);
        @(negedge clk);
        #1;
        rst    = r;
        HReq   = req;
        HLock  = lock;
        HTrans = trans;
        HReady = rdy;
        model_edge(r, req, lock, trans, rdy);
    endtask

    task automatic run(input int n, input logic r, input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] trans, input logic rdy);
        for (int i = 0; i < n; i++) cycle(r, req, lock, trans, rdy);
    endtask

    // Monitor: every falling edge after a queued cycle, compare the registered outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("HGrant",      int'(HGrant),      e.grant);
            check("HMaster",     int'(HMaster),     e.master);
            check("HMasterData", int'(HMasterData), e.mdata);
            check("HMastLock",   int'(HMastLock),   e.lock);
        end
    end

    initial begin
        logic [1:0] req, lock, trans;
        logic       rdy, r;
        rst = 1'b1; HReq = '0; HLock = '0; HTrans = 2'b00; HReady = 1'b1;

        // Reset then idle park
        run(2, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1);
        run(3, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        // Single request from master 1
        run(4, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
        // Contention with beat budget
        run(14, 1'b0, 2'b11, 2'b00, 2'b10, 1'b1);
        // Locked sequence from master 1, then release
        run(12, 1'b0, 2'b11, 2'b10, 2'b10, 1'b1);
        run(4, 1'b0, 2'b11, 2'b00, 2'b10, 1'b1);
        // Wait states while the request moves
        run(3, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1);
        run(3, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
        run(2, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1);
        // Reset during a stalled burst
        run(4, 1'b0, 2'b10, 2'b00, 2'b10, 1'b1);
        run(1, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0);
        run(2, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0);
        run(2, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
        // HLock without HReq is ignored
        run(3, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            req   = 2'($urandom_range(0, 3));
            lock  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            trans = 2'($urandom_range(0, 3));
            rdy   = ($urandom_range(0, 3) != 0);
            r     = ($urandom_range(0, 99) == 0);
            cycle(r, req, lock, trans, rdy);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
